hazard_ctrl: RTL and testbench

Pipeline hazard and flow controller for the 5-stage MIPS core; it drives the ID/EX register's `stall` input, plus the PC and IF/ID hold/flush controls. Each cycle it looks at ID-stage operands, EX/MEM destination and control bits, and the data-memory wait line. From these it decides between load-use or `jr` stalls, branch/jump flushes and a whole-pipeline freeze. Saturating event counters are exposed for performance debug.

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/flow controller: load-use and jr stalls, branch/jump flushes, memory-wait freeze
// Control outputs are combinational from (state, inputs); only state and event counters are registered.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_Jump,
  input  logic        ID_JumpReg,
  input  logic        EX_MemRd,
  input  logic        EX_RegWr,
  input  logic [4:0]  EX_WrReg,
  input  logic        EX_BranchTaken,
  input  logic        MEM_MemRd,
  input  logic [4:0]  MEM_WrReg,
  input  logic        MEM_Wait,
  input  logic        cnt_clr,
  output logic        stall,
  output logic        PC_hold,
  output logic        IFID_hold,
  output logic        IFID_flush,
  output logic        freeze,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_FREEZE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] freeze_cnt_q, freeze_cnt_d;

  logic lu, jrh, haz;
  logic ev_stall, ev_flush, ev_freeze;
  logic stall_c, pc_hold_c, ifid_hold_c, ifid_flush_c, freeze_c;

  // Register $0 is hardwired, so a write to it never creates a dependency.
  always_comb begin
    lu  = EX_MemRd && (EX_WrReg != 5'd0) &&
          ((ID_UseRs && (EX_WrReg == ID_rs)) || (ID_UseRt && (EX_WrReg == ID_rt)));
    jrh = ID_JumpReg && (ID_rs != 5'd0) &&
          ((EX_RegWr && (EX_WrReg == ID_rs)) || (MEM_MemRd && (MEM_WrReg == ID_rs)));
    haz = lu || jrh;
  end

  always_comb begin
    state_d      = state_q;
    stall_c      = 1'b0;
    pc_hold_c    = 1'b0;
    ifid_hold_c  = 1'b0;
    ifid_flush_c = 1'b0;
    freeze_c     = 1'b0;
    ev_stall     = 1'b0;
    ev_flush     = 1'b0;
    ev_freeze    = 1'b0;
    if (reset) begin
      state_d = ST_RUN;
    end else if (MEM_Wait) begin
      freeze_c  = 1'b1;
      ev_freeze = 1'b1;
      state_d   = ST_FREEZE;
    end else begin
      // Leaving FREEZE applies the normal rules in the same cycle.
      state_d = ST_RUN;
      if (EX_BranchTaken) begin
        stall_c      = 1'b1;
        ifid_flush_c = 1'b1;
        ev_flush     = 1'b1;
      end else if (haz) begin
        stall_c     = 1'b1;
        pc_hold_c   = 1'b1;
        ifid_hold_c = 1'b1;
        ev_stall    = 1'b1;
      end else if (ID_Jump) begin
        ifid_flush_c = 1'b1;
        ev_flush     = 1'b1;
      end
    end
  end

  // Clear beats a coincident event; counts saturate instead of wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = 16'h0000;
      flush_cnt_d  = 16'h0000;
      freeze_cnt_d = 16'h0000;
    end else begin
      if (ev_stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (ev_flush && (flush_cnt_q != 16'hFFFF))
        flush_cnt_d = flush_cnt_q + 16'd1;
      if (ev_freeze && (freeze_cnt_q != 16'hFFFF))
        freeze_cnt_d = freeze_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      stall_cnt_q  <= 16'h0000;
      flush_cnt_q  <= 16'h0000;
      freeze_cnt_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall      = stall_c;
  assign PC_hold    = pc_hold_c;
  assign IFID_hold  = ifid_hold_c;
  assign IFID_flush = ifid_flush_c;
  assign freeze     = freeze_c;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt;
  logic        ID_UseRs, ID_UseRt, ID_Jump, ID_JumpReg;
  logic        EX_MemRd, EX_RegWr;
  logic [4:0]  EX_WrReg;
  logic        EX_BranchTaken;
  logic        MEM_MemRd;
  logic [4:0]  MEM_WrReg;
  logic        MEM_Wait;
  logic        cnt_clr;
  logic        stall, PC_hold, IFID_hold, IFID_flush, freeze;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  int checks = 0;
  int errors = 0;

  // Expected control vector {stall, PC_hold, IFID_hold, IFID_flush, freeze}
  logic [4:0] exp_q[$];
  string      tag_q[$];

  localparam logic [4:0] O_NONE   = 5'b00000;
  localparam logic [4:0] O_STALL  = 5'b11100;
  localparam logic [4:0] O_FLUSH  = 5'b00010;
  localparam logic [4:0] O_BRANCH = 5'b10010;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg),
    .EX_MemRd(EX_MemRd), .EX_RegWr(EX_RegWr), .EX_WrReg(EX_WrReg),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemRd(MEM_MemRd), .MEM_WrReg(MEM_WrReg), .MEM_Wait(MEM_Wait),
    .cnt_clr(cnt_clr),
    .stall(stall), .PC_hold(PC_hold), .IFID_hold(IFID_hold),
    .IFID_flush(IFID_flush), .freeze(freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_Jump = 1'b0; ID_JumpReg = 1'b0;
    EX_MemRd = 1'b0; EX_RegWr = 1'b0; EX_WrReg = 5'd0; EX_BranchTaken = 1'b0;
    MEM_MemRd = 1'b0; MEM_WrReg = 5'd0; MEM_Wait = 1'b0; cnt_clr = 1'b0;
  endtask

  // Inputs are already driven; queue the expectation, compare at the falling
  // edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [4:0] exp);
    logic [4:0] obs, want;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {stall, PC_hold, IFID_hold, IFID_flush, freeze};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s: observed ctl=%b expected ctl=%b", t, obs, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(input string tag, input logic [15:0] s, input logic [15:0] f,
                          input logic [15:0] z);
    chk({tag, "_stall_cnt"}, stall_cnt, s);
    chk({tag, "_flush_cnt"}, flush_cnt, f);
    chk({tag, "_freeze_cnt"}, freeze_cnt, z);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    step("reset_out", O_NONE);
    chk_cnts("reset", 16'd0, 16'd0, 16'd0);
    reset = 1'b0;

    // Load-use on rs, then the same case with destination $0
    EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    step("lu_rs", O_STALL);
    chk_cnts("lu_rs", 16'd1, 16'd0, 16'd0);
    EX_WrReg = 5'd0; ID_rs = 5'd0;
    step("lu_r0", O_NONE);
    chk_cnts("lu_r0", 16'd1, 16'd0, 16'd0);

    // Load-use on rt, and a matching rt that is not actually read
    clear_inputs();
    EX_MemRd = 1'b1; EX_WrReg = 5'd9; ID_rt = 5'd9; ID_UseRt = 1'b1;
    step("lu_rt", O_STALL);
    ID_UseRt = 1'b0;
    step("lu_rt_unused", O_NONE);
    chk_cnts("lu_rt", 16'd2, 16'd0, 16'd0);

    clear_inputs();
    cnt_clr = 1'b1;
    step("clr_idle", O_NONE);
    chk_cnts("clr", 16'd0, 16'd0, 16'd0);

    // Load followed by dependent jr $8: stall via EX, stall via MEM, then jump
    clear_inputs();
    ID_Jump = 1'b1; ID_JumpReg = 1'b1; ID_rs = 5'd8; ID_UseRs = 1'b1;
    EX_MemRd = 1'b1; EX_RegWr = 1'b1; EX_WrReg = 5'd8;
    step("ldjr_c1", O_STALL);
    EX_MemRd = 1'b0; EX_RegWr = 1'b0; EX_WrReg = 5'd0;
    MEM_MemRd = 1'b1; MEM_WrReg = 5'd8;
    step("ldjr_c2", O_STALL);
    MEM_MemRd = 1'b0; MEM_WrReg = 5'd0;
    step("ldjr_c3", O_FLUSH);
    chk_cnts("ldjr", 16'd2, 16'd1, 16'd0);

    // Taken branch overrides a coincident load-use
    clear_inputs();
    EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    EX_BranchTaken = 1'b1;
    step("br_lu", O_BRANCH);
    chk_cnts("br_lu", 16'd2, 16'd2, 16'd0);

    // Three wait cycles with a branch held, then release
    clear_inputs();
    EX_BranchTaken = 1'b1; MEM_Wait = 1'b1;
    step("frz_1", O_FREEZE);
    step("frz_2", O_FREEZE);
    step("frz_3", O_FREEZE);
    chk_cnts("frz", 16'd2, 16'd2, 16'd3);
    MEM_Wait = 1'b0;
    step("frz_exit", O_BRANCH);
    chk_cnts("frz_exit", 16'd2, 16'd3, 16'd3);

    // Saturation: 65533 more stall events bring stall_cnt from 2 to 0xFFFF
    clear_inputs();
    EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_reach", stall_cnt, 16'hFFFF);
    step("sat_extra", O_STALL);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    step("sat_clr", O_STALL);
    chk_cnts("sat_clr", 16'd0, 16'd0, 16'd0);

    // Reset in the middle of a freeze forces every output low
    clear_inputs();
    MEM_Wait = 1'b1;
    step("rf_enter", O_FREEZE);
    chk("rf_frzcnt", freeze_cnt, 16'd1);
    reset = 1'b1;
    EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    ID_Jump = 1'b1; EX_BranchTaken = 1'b1;
    step("rf_rst1", O_NONE);
    step("rf_rst2", O_NONE);
    chk_cnts("rf_rst", 16'd0, 16'd0, 16'd0);
    clear_inputs();
    reset = 1'b0;
    step("rf_idle", O_NONE);
    ID_Jump = 1'b1;
    step("rf_jump", O_FLUSH);
    chk_cnts("rf_after", 16'd0, 16'd1, 16'd0);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
